// File: rtl/op_encoder_tx_if.sv
// Link-side bundle of the op encoder: three request/ack channels, the keyboard
// payload inputs, and the serial line with its busy flag and FSM state for debug.
interface op_encoder_tx_if;
  // Handshake: each *_req is a level held by its source until the matching
  // *_ack pulses for exactly one cycle; that pulse is the only completion signal.
  // A request dropped before the frame is loaded is ignored.
  logic        pwr_req;
  logic        pwr_ack;
  logic        audio_req;
  logic        audio_ack;
  logic        kbd_req;
  logic        kbd_ack;
  logic [7:0]  kbd_sel;
  logic [31:0] kbd_data;
  logic        data_out;
  logic        busy;
  logic [2:0]  state;

  modport master (
    output pwr_req, audio_req, kbd_req, kbd_sel, kbd_data,
    input  pwr_ack, audio_ack, kbd_ack, data_out, busy, state
  );

  modport slave (
    input  pwr_req, audio_req, kbd_req, kbd_sel, kbd_data,
    output pwr_ack, audio_ack, kbd_ack, data_out, busy, state
  );
endinterface

// File: rtl/op_encoder_tx.sv
// Transmit side of the monitor-to-host link: arbitrates pwr/audio/kbd requests and
// serialises one start bit, a 16- or 48-bit op MSB-first, a stop bit and idle gap.
module op_encoder_tx #(
  parameter int          BIT_CLKS    = 4,
  parameter int          GAP_BITS    = 2,
  parameter logic [7:0]  AUDIO_COUNT = 8'h10
) (
  input  logic            clk,
  input  logic            reset,
  op_encoder_tx_if.slave  bus
);

  localparam int TW = $clog2(BIT_CLKS);
  localparam logic [TW-1:0] TMR_LAST = TW'(BIT_CLKS - 1);
  localparam logic [5:0]    GAP_CNT  = 6'(GAP_BITS);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] bit_tmr;
  logic [5:0]    bit_cnt;
  logic [47:0]   shift_reg;
  logic          pwr_ack_r;
  logic          audio_ack_r;
  logic          kbd_ack_r;
  logic          bit_end;

  assign bit_end = (bit_tmr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_tmr     <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      pwr_ack_r   <= 1'b0;
      audio_ack_r <= 1'b0;
      kbd_ack_r   <= 1'b0;
    end else begin
      pwr_ack_r   <= 1'b0;
      audio_ack_r <= 1'b0;
      kbd_ack_r   <= 1'b0;
      // The bit timer free-runs in every line-driving state and reloads each bit period.
      if (state != IDLE && state != LOAD) begin
        bit_tmr <= bit_end ? TMR_LAST : bit_tmr - 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.pwr_req || bus.audio_req || bus.kbd_req) state <= LOAD;
        end
        LOAD: begin
          bit_tmr <= TMR_LAST;
          bit_cnt <= 6'd16;
          state   <= START;
          if (bus.pwr_req) begin
            shift_reg <= {16'hc5ef, 32'h0};
            pwr_ack_r <= 1'b1;
          end else if (bus.audio_req) begin
            shift_reg   <= {8'h07, AUDIO_COUNT, 32'h0};
            audio_ack_r <= 1'b1;
          end else if (bus.kbd_req) begin
            shift_reg <= {8'hc6, bus.kbd_sel, bus.kbd_data};
            bit_cnt   <= 6'd48;
            kbd_ack_r <= 1'b1;
          end else begin
            // Request withdrawn before it could be loaded: nothing to send.
            state <= IDLE;
          end
        end
        START: begin
          if (bit_end) state <= SHIFT;
        end
        SHIFT: begin
          if (bit_end) begin
            shift_reg <= {shift_reg[46:0], 1'b0};
            bit_cnt   <= bit_cnt - 6'd1;
            if (bit_cnt == 6'd1) state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (GAP_BITS == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              bit_cnt <= GAP_CNT;
            end
          end
        end
        GAP: begin
          if (bit_end) begin
            bit_cnt <= bit_cnt - 6'd1;
            if (bit_cnt == 6'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out  = (state == START) || ((state == SHIFT) && shift_reg[47]);
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;
  assign bus.pwr_ack   = pwr_ack_r;
  assign bus.audio_ack = audio_ack_r;
  assign bus.kbd_ack   = kbd_ack_r;

endmodule

// File: tb/tb_op_encoder_tx.sv
// Bench for op_encoder_tx: default instance plus a BIT_CLKS=2/GAP_BITS=0 instance,
// frames predicted from the op rules and compared as whole line waveforms.
module tb_op_encoder_tx;
  localparam int BC1 = 4;
  localparam int GB1 = 2;
  localparam int BC2 = 2;
  localparam int GB2 = 0;
  localparam logic [7:0] AC = 8'h10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  op_encoder_tx_if bus1();
  op_encoder_tx_if bus2();

  op_encoder_tx #(.BIT_CLKS(BC1), .GAP_BITS(GB1), .AUDIO_COUNT(AC)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  op_encoder_tx #(.BIT_CLKS(BC2), .GAP_BITS(GB2), .AUDIO_COUNT(AC)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  // Scoreboard entries: {nbits[6:0], frame bits left-aligned in 48}
  logic [54:0] exp_q1[$];
  logic [54:0] exp_q2[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_at[3];
  int issued[3];
  int pulses[3];
  int ack_hi[3];
  logic [2:0] prev_ack = 3'b000;
  logic [2:0] acks1;
  logic abort1 = 1'b0;

  assign acks1 = {bus1.kbd_ack, bus1.audio_ack, bus1.pwr_ack};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (acks1[s]) begin
        ack_hi[s] <= ack_hi[s] + 1;
        if (!prev_ack[s]) pulses[s] <= pulses[s] + 1;
      end
    end
    prev_ack <= acks1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [54:0] frame_of(input int src, input logic [7:0] sel,
                                           input logic [31:0] data);
    case (src)
      0:       return {7'd16, 16'hc5ef, 32'h0};
      1:       return {7'd16, 8'h07, AC, 32'h0};
      default: return {7'd48, 8'hc6, sel, data};
    endcase
  endfunction

  // Expected line level at sample i of a busy period (sample 0 is the load cycle).
  function automatic logic exp_wave_bit(input logic [47:0] val, input int nbits,
                                        input int bc, input int i);
    int b;
    if (i == 0) return 1'b0;
    b = (i - 1) / bc;
    if (b == 0) return 1'b1;
    if (b <= nbits) return val[47 - (b - 1)];
    return 1'b0;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 1) ? bus1.busy : bus2.busy;
  endfunction

  function automatic logic dout_of(input int w);
    return (w == 1) ? bus1.data_out : bus2.data_out;
  endfunction

  function automatic logic ack_of(input int w, input int s);
    if (w == 1) return (s == 0) ? bus1.pwr_ack : (s == 1) ? bus1.audio_ack : bus1.kbd_ack;
    return (s == 0) ? bus2.pwr_ack : (s == 1) ? bus2.audio_ack : bus2.kbd_ack;
  endfunction

  task automatic set_req(input int w, input int s, input logic v);
    if (w == 1) begin
      case (s)
        0:       bus1.pwr_req = v;
        1:       bus1.audio_req = v;
        default: bus1.kbd_req = v;
      endcase
    end else begin
      case (s)
        0:       bus2.pwr_req = v;
        1:       bus2.audio_req = v;
        default: bus2.kbd_req = v;
      endcase
    end
  endtask

  task automatic monitor_frame(input int w);
    logic [54:0] e;
    int nb, bc, gb, len, first_bad;
    bc = (w == 1) ? BC1 : BC2;
    gb = (w == 1) ? GB1 : GB2;
    e = '0;
    check($sformatf("frame%0d_expected", w), 64'((w == 1) ? exp_q1.size() : exp_q2.size()) != 0, 64'd1);
    if (w == 1 && exp_q1.size() != 0) e = exp_q1.pop_front();
    if (w == 2 && exp_q2.size() != 0) e = exp_q2.pop_front();
    nb = int'(e[54:48]);
    len = 0;
    first_bad = -1;
    while (busy_of(w) && len < 1000) begin
      if (dout_of(w) !== exp_wave_bit(e[47:0], nb, bc, len) && first_bad < 0) first_bad = len;
      len++;
      @(negedge clk);
    end
    if (w == 1 && abort1) begin
      abort1 = 1'b0;
    end else begin
      check($sformatf("frame%0d_len_op%04h", w, e[47:32]), 64'(len), 64'(1 + (2 + nb + gb) * bc));
      check($sformatf("frame%0d_first_bad_sample_op%04h", w, e[47:32]), 64'(first_bad), 64'(-1));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus1.busy) monitor_frame(1);
      else check("idle_line1", 64'(bus1.data_out), 64'd0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus2.busy) monitor_frame(2);
      else check("idle_line2", 64'(bus2.data_out), 64'd0);
    end
  end

  // Issues a set of simultaneous requests (bit0 pwr, bit1 audio, bit2 kbd) at a negedge
  // and holds each until its ack; the model orders the expected frames by priority.
  task automatic issue_batch(input int w, input logic [2:0] mask,
                             input logic [7:0] sel, input logic [31:0] data);
    logic [2:0] pend;
    int t;
    if (w == 1) begin bus1.kbd_sel = sel; bus1.kbd_data = data; end
    else        begin bus2.kbd_sel = sel; bus2.kbd_data = data; end
    for (int s = 0; s < 3; s++) begin
      if (mask[s]) begin
        if (w == 1) begin exp_q1.push_back(frame_of(s, sel, data)); issued[s]++; end
        else exp_q2.push_back(frame_of(s, sel, data));
        set_req(w, s, 1'b1);
      end
    end
    pend = mask;
    t = 0;
    while (pend != 3'b000 && t < 3000) begin
      @(negedge clk);
      t++;
      for (int s = 0; s < 3; s++) begin
        if (pend[s] && ack_of(w, s)) begin
          pend[s] = 1'b0;
          set_req(w, s, 1'b0);
          ack_at[s] = cyc;
          // Payload inputs change after load; the frame in flight must not follow them.
          if (s == 2 && w == 1) begin bus1.kbd_sel = ~sel; bus1.kbd_data = ~data; end
        end
      end
    end
    check("batch_acks_timeout", 64'(pend), 64'd0);
  endtask

  task automatic wait_idle(input int w);
    int t = 0;
    while (busy_of(w) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("wait_idle%0d_timeout", w), 64'(busy_of(w)), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, snap;
    for (int s = 0; s < 3; s++) begin issued[s] = 0; pulses[s] = 0; ack_hi[s] = 0; end
    reset = 1'b1;
    bus1.pwr_req = 0; bus1.audio_req = 0; bus1.kbd_req = 0; bus1.kbd_sel = 0; bus1.kbd_data = 0;
    bus2.pwr_req = 0; bus2.audio_req = 0; bus2.kbd_req = 0; bus2.kbd_sel = 0; bus2.kbd_data = 0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus1.busy), 64'd0);
    check("reset_data_out", 64'(bus1.data_out), 64'd0);
    check("reset_acks", 64'(acks1), 64'd0);
    check("reset_state", 64'(bus1.state), 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single pwr frame from idle; ack two cycles after the request rises.
    t0 = cyc;
    issue_batch(1, 3'b001, 8'h00, 32'h0);
    check("pwr_ack_latency", 64'(ack_at[0] - t0), 64'd2);
    wait_idle(1);

    // kbd frame with known payload, payload inputs flipped mid-frame.
    issue_batch(1, 3'b100, 8'h01, 32'hdeadbeef);
    wait_idle(1);

    // All three together: priority order, ack spacing = frame + IDLE + LOAD.
    issue_batch(1, 3'b111, 8'($urandom), $urandom);
    check("pwr_to_audio_ack_gap", 64'(ack_at[1] - ack_at[0]), 64'((2 + 16 + GB1) * BC1 + 2));
    check("audio_to_kbd_ack_gap", 64'(ack_at[2] - ack_at[1]), 64'((2 + 16 + GB1) * BC1 + 2));
    wait_idle(1);

    // Audio raised while a kbd frame is on the line waits for the whole gap.
    issue_batch(1, 3'b100, 8'($urandom), $urandom);
    repeat ($urandom_range(10, 100)) @(negedge clk);
    issue_batch(1, 3'b010, 8'h00, 32'h0);
    check("kbd_to_audio_ack_gap", 64'(ack_at[1] - ack_at[2]), 64'((2 + 48 + GB1) * BC1 + 2));
    wait_idle(1);

    // Reset during bit 20 of a kbd frame.
    issue_batch(1, 3'b100, 8'h5a, 32'h12345678);
    repeat (1 + BC1 + 20 * BC1) @(negedge clk);
    abort1 = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("async_reset_data_out", 64'(bus1.data_out), 64'd0);
    check("async_reset_busy", 64'(bus1.busy), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    snap = pulses[0] + pulses[1] + pulses[2];
    repeat (40) @(negedge clk);
    check("post_reset_no_acks", 64'(pulses[0] + pulses[1] + pulses[2]), 64'(snap));
    check("post_reset_busy", 64'(bus1.busy), 64'd0);

    // Short-bit instance: 36-cycle pwr frame, pending audio loaded right after.
    issue_batch(2, 3'b011, 8'h00, 32'h0);
    check("fast_pwr_to_audio_ack_gap", 64'(ack_at[1] - ack_at[0]), 64'((2 + 16 + GB2) * BC2 + 2));
    wait_idle(2);

    // Random batches, overlapping the previous frame on the line.
    for (int n = 0; n < 10; n++) begin
      issue_batch(1, 3'($urandom_range(1, 7)), 8'($urandom), $urandom);
      repeat ($urandom_range(0, 150)) @(negedge clk);
    end
    wait_idle(1);
    repeat (3) @(negedge clk);

    check("scoreboard1_empty", 64'(exp_q1.size()), 64'd0);
    check("scoreboard2_empty", 64'(exp_q2.size()), 64'd0);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("ack_pulses_src%0d", s), 64'(pulses[s]), 64'(issued[s]));
      check($sformatf("ack_width_src%0d", s), 64'(ack_hi[s]), 64'(issued[s]));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
